// File: rtl/mem_arbiter.sv
// Two-master arbiter for the byte-wide memory port: the eJ32 core and a host agent
// (loader/dumper) share one port. The core has priority, the host is protected from
// starvation, and host bursts are bounded so the core always gets a beat in.
module mem_arbiter #(
  parameter int unsigned ASZ       = 17,
  parameter int unsigned DSZ       = 8,
  parameter int unsigned BURST_MAX = 16,
  parameter int unsigned STARVE    = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  // core byte-bus master
  input  logic           core_req_i,
  input  logic           core_we_i,
  input  logic [ASZ-1:0] core_a_i,
  input  logic [DSZ-1:0] core_vo_i,
  output logic [DSZ-1:0] core_vi_o,
  output logic           core_stall_o,
  // host agent
  input  logic           host_req_i,
  input  logic           host_we_i,
  input  logic [ASZ-1:0] host_a_i,
  input  logic [DSZ-1:0] host_vo_i,
  output logic           host_gnt_o,
  output logic [DSZ-1:0] host_vi_o,
  output logic           host_ack_o,
  // memory port
  output logic           mem_we_o,
  output logic [ASZ-1:0] mem_a_o,
  output logic [DSZ-1:0] mem_vi_o,
  input  logic [DSZ-1:0] mem_vo_i,
  // trace
  output logic [1:0]     owner_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCore  = 2'd1,
    StHost  = 2'd2,
    StYield = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RdNone = 2'd0,
    RdCore = 2'd1,
    RdHost = 2'd2
  } rd_owner_e;

  localparam int unsigned BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam int unsigned SW = $clog2(STARVE + 1);
  localparam logic [BW-1:0] BurstLast = BW'(BURST_MAX - 1);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE);

  state_e         state_q, state_d;
  logic [BW-1:0]  burst_q, burst_d;
  logic [SW-1:0]  starve_q, starve_d;
  rd_owner_e      rd_owner_q, rd_owner_d;
  logic           core_beat, host_beat;

  // Next-state, burst/starvation accounting and beat selection.
  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    starve_d  = starve_q;
    core_beat = 1'b0;
    host_beat = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Core is served straight from idle unless the host has already waited too long.
        if (core_req_i && !(host_req_i && starve_q == StarveMax)) begin
          core_beat = 1'b1;
          state_d   = StCore;
        end else if (host_req_i) begin
          state_d = StHost;
        end
      end
      StCore: begin
        core_beat = core_req_i;
        if (!core_req_i) begin
          state_d = host_req_i ? StHost : StIdle;
        end
      end
      StHost: begin
        host_beat = host_req_i;
        if (!host_req_i) begin
          state_d = StIdle;
          burst_d = '0;
        end else if (burst_q == BurstLast) begin
          // Burst budget spent: hand the core one beat if it is waiting.
          burst_d = '0;
          if (core_req_i) begin
            state_d = StYield;
          end
        end else begin
          burst_d = burst_q + 1'b1;
        end
      end
      StYield: begin
        core_beat = core_req_i;
        burst_d   = '0;
        if (host_req_i) begin
          state_d = StHost;
        end else if (core_req_i) begin
          state_d = StCore;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Count core beats taken while the host waits; the beat that reaches the limit is
    // the last one before the host is forced in.
    if (state_q == StHost || state_q == StYield || !host_req_i) begin
      starve_d = '0;
    end else if (core_beat && starve_q != StarveMax) begin
      starve_d = starve_q + 1'b1;
    end
    if ((state_q == StIdle || state_q == StCore) && core_beat && host_req_i &&
        starve_d == StarveMax) begin
      state_d = StHost;
    end

    // No beat may reach memory while reset is held.
    if (!rst_ni) begin
      core_beat = 1'b0;
      host_beat = 1'b0;
    end
  end

  // Port mux, strobes and read-return steering.
  always_comb begin
    host_gnt_o   = host_beat;
    core_stall_o = core_req_i && !core_beat && (state_q != StIdle);
    mem_we_o     = (host_beat && host_we_i) || (core_beat && core_we_i);
    mem_a_o      = '0;
    mem_vi_o     = '0;
    if (host_beat) begin
      mem_a_o  = host_a_i;
      mem_vi_o = host_vo_i;
    end else if (core_beat) begin
      mem_a_o  = core_a_i;
      mem_vi_o = core_vo_i;
    end

    rd_owner_d = RdNone;
    if (host_beat && !host_we_i) begin
      rd_owner_d = RdHost;
    end else if (core_beat && !core_we_i) begin
      rd_owner_d = RdCore;
    end

    host_ack_o = (rd_owner_q == RdHost);
    host_vi_o  = (rd_owner_q == RdHost) ? mem_vo_i : '0;
    core_vi_o  = (rd_owner_q == RdCore) ? mem_vo_i : '0;
    owner_o    = state_q;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      burst_q    <= '0;
      starve_q   <= '0;
      rd_owner_q <= RdNone;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      starve_q   <= starve_d;
      rd_owner_q <= rd_owner_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for the core-priority/starvation path,
// then hand sequences for host load, burst limit, read ordering, reset and address wrap.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we;
  logic [16:0] core_a;
  logic [7:0]  core_vo, core_vi;
  logic        core_stall;
  logic        host_req, host_we;
  logic [16:0] host_a;
  logic [7:0]  host_vo, host_vi;
  logic        host_gnt, host_ack;
  logic        mem_we;
  logic [16:0] mem_a;
  logic [7:0]  mem_vi, mem_vo;
  logic [1:0]  owner;

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .core_req_i  (core_req),
    .core_we_i   (core_we),
    .core_a_i    (core_a),
    .core_vo_i   (core_vo),
    .core_vi_o   (core_vi),
    .core_stall_o(core_stall),
    .host_req_i  (host_req),
    .host_we_i   (host_we),
    .host_a_i    (host_a),
    .host_vo_i   (host_vo),
    .host_gnt_o  (host_gnt),
    .host_vi_o   (host_vi),
    .host_ack_o  (host_ack),
    .mem_we_o    (mem_we),
    .mem_a_o     (mem_a),
    .mem_vi_o    (mem_vi),
    .mem_vo_i    (mem_vo),
    .owner_o     (owner)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous write, registered read with one cycle of latency.
  logic [7:0] mem [0:131071];
  always @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_vi;
    mem_vo <= mem[mem_a];
  end

  typedef struct {
    logic        core_req;
    logic        core_we;
    logic [16:0] core_a;
    logic        host_req;
    logic        host_we;
    logic [16:0] host_a;
    logic [7:0]  host_vo;
    logic        exp_stall;
    logic        exp_gnt;
    logic        exp_we;
    logic [16:0] exp_a;
    logic [1:0]  exp_owner;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req = 1'b0; core_we = 1'b0; core_a = '0; core_vo = '0;
    host_req = 1'b0; host_we = 1'b0; host_a = '0; host_vo = '0;
  endtask

  // Called with inputs already driven this cycle; returns at the negedge of the grant.
  task automatic wait_gnt(input string name);
    int k = 0;
    @(negedge clk);
    while (!host_gnt && k < 10) begin
      cyc();
      @(negedge clk);
      k++;
    end
    chk({name, " gnt"}, 32'(host_gnt), 32'd1);
  endtask

  task automatic host_write(input logic [16:0] a, input logic [7:0] d);
    cyc();
    host_req = 1'b1; host_we = 1'b1; host_a = a; host_vo = d;
    wait_gnt("hwr");
    cyc();
    host_req = 1'b0; host_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int fg;
    int lg;
    logic egnt;

    tbl[0]  = '{1'b1, 1'b0, 17'h10, 1'b1, 1'b1, 17'h1400, 8'h77, 1'b0, 1'b0, 1'b0, 17'h10, 2'd0};
    for (int i = 1; i < 8; i++) begin
      tbl[i] = '{1'b1, 1'b0, 17'(32'h10 + i), 1'b1, 1'b1, 17'h1400, 8'h77,
                 1'b0, 1'b0, 1'b0, 17'(32'h10 + i), 2'd1};
    end
    tbl[8]  = '{1'b1, 1'b0, 17'h18, 1'b1, 1'b1, 17'h1400, 8'h77, 1'b1, 1'b1, 1'b1, 17'h1400, 2'd2};
    tbl[9]  = '{1'b1, 1'b0, 17'h18, 1'b0, 1'b0, 17'h0,    8'h00, 1'b1, 1'b0, 1'b0, 17'h0,    2'd2};
    tbl[10] = '{1'b1, 1'b0, 17'h18, 1'b0, 1'b0, 17'h0,    8'h00, 1'b0, 1'b0, 1'b0, 17'h18,   2'd0};
    tbl[11] = '{1'b0, 1'b0, 17'h0,  1'b0, 1'b0, 17'h0,    8'h00, 1'b0, 1'b0, 1'b0, 17'h0,    2'd1};
    tbl[12] = '{1'b0, 1'b0, 17'h0,  1'b0, 1'b0, 17'h0,    8'h00, 1'b0, 1'b0, 1'b0, 17'h0,    2'd0};

    // Reset state, with requests active to show they are ignored.
    idle_inputs();
    rst_n = 1'b0;
    core_req = 1'b1; core_we = 1'b1; core_a = 17'h55; core_vo = 8'h99;
    host_req = 1'b1; host_we = 1'b1; host_a = 17'h66;
    @(negedge clk);
    chk("rst stall", 32'(core_stall), 0);
    chk("rst gnt",   32'(host_gnt), 0);
    chk("rst ack",   32'(host_ack), 0);
    chk("rst we",    32'(mem_we), 0);
    chk("rst a",     32'(mem_a), 0);
    chk("rst vi",    32'(mem_vi), 0);
    chk("rst cvi",   32'(core_vi), 0);
    chk("rst hvi",   32'(host_vi), 0);
    chk("rst owner", 32'(owner), 0);
    cyc();
    rst_n = 1'b1;
    idle_inputs();

    // Core priority and starvation hand-over.
    for (int i = 0; i < 13; i++) begin
      cyc();
      core_req = tbl[i].core_req; core_we = tbl[i].core_we; core_a = tbl[i].core_a;
      host_req = tbl[i].host_req; host_we = tbl[i].host_we; host_a = tbl[i].host_a;
      host_vo  = tbl[i].host_vo;
      @(negedge clk);
      chk($sformatf("vec%0d stall", i), 32'(core_stall), 32'(tbl[i].exp_stall));
      chk($sformatf("vec%0d gnt", i),   32'(host_gnt),   32'(tbl[i].exp_gnt));
      chk($sformatf("vec%0d we", i),    32'(mem_we),     32'(tbl[i].exp_we));
      chk($sformatf("vec%0d a", i),     32'(mem_a),      32'(tbl[i].exp_a));
      chk($sformatf("vec%0d owner", i), 32'(owner),      32'(tbl[i].exp_owner));
      chk($sformatf("vec%0d ack", i),   32'(host_ack),   0);
    end

    // Host-only load of 0x41..0x50 into 0x1000..0x100F.
    n = 0; fg = -1; lg = -1;
    for (int c = 0; c < 30 && n < 16; c++) begin
      cyc();
      host_req = 1'b1; host_we = 1'b1;
      host_a = 17'(32'h1000 + n); host_vo = 8'(32'h41 + n);
      @(negedge clk);
      chk("load ack", 32'(host_ack), 0);
      if (host_gnt) begin
        chk("load we", 32'(mem_we), 1);
        chk("load a",  32'(mem_a), 32'h1000 + n);
        if (fg < 0) fg = c;
        lg = c;
        n++;
      end
    end
    chk("load grants", 32'(n), 16);
    chk("load consecutive", 32'(lg - fg + 1), 16);
    cyc();
    host_req = 1'b0; host_we = 1'b0;
    @(negedge clk);
    chk("load drop gnt", 32'(host_gnt), 0);
    cyc();
    @(negedge clk);
    chk("load idle", 32'(owner), 0);

    // Host read of 0x1005: ack one cycle after the grant.
    cyc();
    host_req = 1'b1; host_we = 1'b0; host_a = 17'h1005;
    wait_gnt("hrd");
    chk("hrd ack at gnt", 32'(host_ack), 0);
    cyc();
    host_req = 1'b0;
    @(negedge clk);
    chk("hrd ack",  32'(host_ack), 1);
    chk("hrd data", 32'(host_vi), 32'h46);

    // Burst limit: 40 host writes with the core requesting throughout.
    cyc();
    host_req = 1'b1; host_we = 1'b1; host_a = 17'h2000; host_vo = 8'h00;
    @(negedge clk);
    chk("burst start gnt", 32'(host_gnt), 0);
    n = 0;
    for (int i = 0; i < 42; i++) begin
      cyc();
      core_req = 1'b1; core_we = 1'b0; core_a = 17'h0123;
      host_a = 17'(32'h2000 + n); host_vo = 8'(n);
      @(negedge clk);
      egnt = !(i == 16 || i == 33);
      chk($sformatf("burst%0d gnt", i),   32'(host_gnt), 32'(egnt));
      chk($sformatf("burst%0d owner", i), 32'(owner), egnt ? 32'd2 : 32'd3);
      chk($sformatf("burst%0d stall", i), 32'(core_stall), 32'(egnt));
      chk($sformatf("burst%0d we", i),    32'(mem_we), 32'(egnt));
      chk($sformatf("burst%0d a", i),     32'(mem_a), egnt ? 32'h2000 + n : 32'h0123);
      if (host_gnt) n++;
    end
    chk("burst total", 32'(n), 40);
    cyc();
    host_req = 1'b0; host_we = 1'b0;
    @(negedge clk);
    chk("burst tail owner", 32'(owner), 2);
    chk("burst tail stall", 32'(core_stall), 1);
    cyc();
    core_req = 1'b0;
    @(negedge clk);
    chk("burst end idle", 32'(owner), 0);

    // Mixed read ordering: core reads 0x0000 (0xA5), host reads 0x1400 (0x5A).
    host_write(17'h0000, 8'hA5);
    host_write(17'h1400, 8'h5A);
    for (int i = 0; i < 12; i++) begin
      cyc();
      core_req = (i <= 10); core_we = 1'b0; core_a = 17'h0000;
      host_req = (i <= 8);  host_we = 1'b0; host_a = 17'h1400;
      @(negedge clk);
      chk($sformatf("mix%0d owner", i), 32'(owner),
          (i == 0 || i == 10) ? 32'd0 : (i >= 8 && i <= 9) ? 32'd2 : 32'd1);
      chk($sformatf("mix%0d ack", i), 32'(host_ack), 32'(i == 9));
      if (i == 9) begin
        chk("mix host data", 32'(host_vi), 32'h5A);
        chk("mix no cross", 32'(core_vi == 8'h5A), 0);
        chk("mix stall", 32'(core_stall), 1);
      end
      if ((i >= 1 && i <= 8) || i == 11) begin
        chk($sformatf("mix%0d core data", i), 32'(core_vi), 32'hA5);
      end
    end

    // Reset during beat 5 of a host write burst.
    host_write(17'h3004, 8'hEE);
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      cyc();
      host_req = 1'b1; host_we = 1'b1;
      host_a = 17'(32'h3000 + n); host_vo = 8'(32'h90 + n);
      @(negedge clk);
      if (host_gnt) n++;
    end
    chk("rstb beats", 32'(n), 4);
    cyc();
    host_a = 17'h3004; host_vo = 8'h94; core_req = 1'b1; core_we = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstb gnt",   32'(host_gnt), 0);
    chk("rstb we",    32'(mem_we), 0);
    chk("rstb a",     32'(mem_a), 0);
    chk("rstb stall", 32'(core_stall), 0);
    chk("rstb ack",   32'(host_ack), 0);
    chk("rstb owner", 32'(owner), 0);
    chk("rstb cvi",   32'(core_vi), 0);
    cyc();
    @(negedge clk);
    chk("rstb we2", 32'(mem_we), 0);
    cyc();
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk("rstb idle", 32'(owner), 0);
    chk("rstb mem kept", 32'(mem[17'h3004]), 32'hEE);

    // Address wrap: 0x1FFFF then 0x00000.
    cyc();
    host_req = 1'b1; host_we = 1'b1; host_a = 17'h1FFFF; host_vo = 8'h11;
    wait_gnt("wrap0");
    chk("wrap0 a", 32'(mem_a), 32'h1FFFF);
    cyc();
    host_a = 17'h00000; host_vo = 8'h22;
    @(negedge clk);
    chk("wrap1 gnt", 32'(host_gnt), 1);
    chk("wrap1 a",   32'(mem_a), 0);
    cyc();
    host_req = 1'b0; host_we = 1'b0;
    cyc();
    @(negedge clk);
    chk("wrap mem top", 32'(mem[17'h1FFFF]), 32'h11);
    chk("wrap mem zero", 32'(mem[17'h00000]), 32'h22);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
